// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: 8N1 UART transmitter, LSB first, with a busy/done handshake
// for the upstream character sequencer.
//
// Optional build macro UART_TX_PARITY_EN: inserts an even-parity bit between the
// last data bit and the stop bit (frame becomes 11 bit times).
//
// Ports:
//   clk      - system clock, rising edge
//   rst_n    - asynchronous active-low reset; aborts any frame in flight
//   tx_start - send request, honoured only while idle
//   tx_data  - byte to send, captured on the accepted tx_start cycle
//   tx_busy  - high from the cycle after acceptance until the frame completes
//   tx_done  - one-cycle pulse on the cycle the transmitter returns to idle
//   txd      - registered serial line, idle high
module uart_tx_serializer #(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned CNT_W        = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       txd
);

   localparam int unsigned DATA_W = 8;
   localparam int unsigned IDX_W  = 3;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic              txd_d, busy_d, done_d;
   logic              bit_end;
`ifdef UART_TX_PARITY_EN
   logic              par_q, par_d;
`endif

   assign bit_end = (cnt_q == CNT_LAST);

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         txd     <= 1'b1;
         tx_busy <= 1'b0;
         tx_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         txd     <= txd_d;
         tx_busy <= busy_d;
         tx_done <= done_d;
`ifdef UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   // Next state; txd_d is the line value for the cycle after this edge
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      txd_d   = 1'b1;
      busy_d  = 1'b1;
      done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d   = par_q;
`endif

      // Baud counter wraps at every bit boundary while a frame is running
      if (state_q != IDLE) begin
         cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
      end

      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (tx_start) begin
               shift_d = tx_data;
               cnt_d   = '0;
               idx_d   = '0;
               state_d = START;
               txd_d   = 1'b0;
               busy_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
               par_d   = ^tx_data;
`endif
            end
         end
         START: begin
            txd_d = 1'b0;
            if (bit_end) begin
               state_d = DATA;
               txd_d   = shift_q[0];
            end
         end
         DATA: begin
            txd_d = shift_q[0];
            if (bit_end) begin
               shift_d = shift_q >> 1;
               idx_d   = idx_q + IDX_W'(1);
               txd_d   = shift_q[1];
               if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                  state_d = PARITY;
                  txd_d   = par_q;
`else
                  state_d = STOP;
                  txd_d   = 1'b1;
`endif
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            txd_d = par_q;
            if (bit_end) begin
               state_d = STOP;
               txd_d   = 1'b1;
            end
         end
`endif
         STOP: begin
            if (bit_end) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: scoreboard bench for uart_tx_serializer at CLKS_PER_BIT=4.
// Expected bytes are queued when a send is requested; a line receiver samples
// every cycle of each frame and the scenario tasks compare the decoded frame.
module tb_uart_tx_serializer;

   localparam int unsigned CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam int unsigned NB = 11;
`else
   localparam int unsigned NB = 10;
`endif
   localparam int FRAME = NB * CPB;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tx_start = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_busy, tx_done, txd;

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];

   typedef struct {
      logic [10:0] bits;
      bit          shape_ok;
      bit          busy_ok;
      bit          early_done;
      int          done_lat;
      logic        busy_at_done;
      int          wait_n;
   } frame_t;

   uart_tx_serializer #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .tx_busy  (tx_busy),
      .tx_done  (tx_done),
      .txd      (txd)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference line image: start=0, data LSB first, [even parity], stop=1
   function automatic logic [10:0] frame_bits(input logic [7:0] d);
      logic [10:0] b;
      b      = '1;
      b[0]   = 1'b0;
      b[8:1] = d;
`ifdef UART_TX_PARITY_EN
      b[9]   = ^d;
`endif
      return b;
   endfunction

   // Receiver: waits for the start edge, samples all NB*CPB cycles, then looks for tx_done
   task automatic rx_frame(output frame_t fr);
      logic v;
      fr.bits = '1; fr.shape_ok = 1'b1; fr.busy_ok = 1'b1; fr.early_done = 1'b0;
      fr.done_lat = -1; fr.busy_at_done = 1'bx; fr.wait_n = 0;
      do begin
         @(negedge clk);
         fr.wait_n++;
      end while (txd !== 1'b0 && fr.wait_n < 2000);
      if (txd !== 1'b0) return;
      for (int k = 0; k < FRAME; k++) begin
         if (k != 0) @(negedge clk);
         v = txd;
         if (k % CPB == 0) fr.bits[k / CPB] = v;
         else if (v !== fr.bits[k / CPB]) fr.shape_ok = 1'b0;
         if (tx_busy !== 1'b1) fr.busy_ok = 1'b0;
         if (tx_done !== 1'b0) fr.early_done = 1'b1;
      end
      for (int k = FRAME; k < FRAME + 8; k++) begin
         @(negedge clk);
         if (tx_done === 1'b1) begin
            fr.done_lat = k;
            fr.busy_at_done = tx_busy;
            break;
         end
      end
   endtask

   task automatic test_reset();
      int bad;
      rst_n = 1'b0; tx_start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      checks++; if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b expected 1", txd); end
      checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", tx_busy); end
      checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", tx_done); end
      bad = 0;
      repeat (50) begin
         @(negedge clk);
         if (txd !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL reset_idle: %0d active cycles, expected 0", bad); end
   endtask

   task automatic test_single();
      frame_t fr;
      logic [7:0] e;
      exp_q.push_back(8'h41);
      fork
         begin @(negedge clk); tx_data = 8'h41; tx_start = 1'b1; @(negedge clk); tx_start = 1'b0; end
         rx_frame(fr);
      join
      e = exp_q.pop_front();
      checks++; if (fr.wait_n != 2) begin errors++; $display("FAIL single_start_latency: fall seen at sample %0d expected 2", fr.wait_n); end
      checks++; if (fr.bits !== frame_bits(e)) begin errors++; $display("FAIL single_bits: got %b expected %b", fr.bits, frame_bits(e)); end
      checks++; if (!fr.shape_ok) begin errors++; $display("FAIL single_shape: bit not stable for %0d cycles", CPB); end
      checks++; if (!fr.busy_ok) begin errors++; $display("FAIL single_busy: tx_busy low inside frame, expected 1"); end
      checks++; if (fr.early_done) begin errors++; $display("FAIL single_early_done: tx_done inside frame, expected none"); end
      checks++; if (fr.done_lat != FRAME) begin errors++; $display("FAIL single_done_lat: got %0d expected %0d", fr.done_lat, FRAME); end
      checks++; if (fr.busy_at_done !== 1'b0) begin errors++; $display("FAIL single_busy_at_done: got %b expected 0", fr.busy_at_done); end
      @(negedge clk);
      checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL single_done_width: got %b expected 0", tx_done); end
   endtask

   task automatic test_back_to_back();
      frame_t f1, f2;
      logic [7:0] e;
      int n, bad;
      exp_q.push_back(8'h41);
      exp_q.push_back(8'h42);
      fork
         begin
            @(negedge clk); tx_data = 8'h41; tx_start = 1'b1;
            @(negedge clk); tx_data = 8'h42;
            n = 0;
            while (tx_done !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
            @(negedge clk); tx_start = 1'b0;
         end
         begin rx_frame(f1); rx_frame(f2); end
      join
      e = exp_q.pop_front();
      checks++; if (f1.bits !== frame_bits(e)) begin errors++; $display("FAIL b2b_first_bits: got %b expected %b", f1.bits, frame_bits(e)); end
      checks++; if (f1.done_lat != FRAME) begin errors++; $display("FAIL b2b_first_done_lat: got %0d expected %0d", f1.done_lat, FRAME); end
      e = exp_q.pop_front();
      checks++; if (f2.bits !== frame_bits(e)) begin errors++; $display("FAIL b2b_second_bits: got %b expected %b", f2.bits, frame_bits(e)); end
      // Only the single IDLE/done cycle may separate the stop bit from the next start bit
      checks++; if (f2.wait_n != 1) begin errors++; $display("FAIL b2b_gap: start fell after %0d cycles expected 1", f2.wait_n); end
      checks++; if (!(f1.shape_ok && f2.shape_ok)) begin errors++; $display("FAIL b2b_shape: unstable bit, expected stable"); end
      checks++; if (f2.done_lat != FRAME) begin errors++; $display("FAIL b2b_second_done_lat: got %0d expected %0d", f2.done_lat, FRAME); end
      bad = 0;
      repeat (20) begin @(negedge clk); if (txd !== 1'b1 || tx_busy !== 1'b0) bad++; end
      checks++; if (bad != 0) begin errors++; $display("FAIL b2b_no_third: %0d active cycles, expected 0", bad); end
   endtask

   task automatic test_ignore_busy();
      frame_t fr;
      logic [7:0] e;
      int dones, lows;
      exp_q.push_back(8'h43);
      fork
         begin
            @(negedge clk); tx_data = 8'h43; tx_start = 1'b1;
            @(negedge clk); tx_start = 1'b0;
            repeat (12) @(negedge clk);
            tx_data = 8'h50; tx_start = 1'b1;
            @(negedge clk); tx_start = 1'b0;
         end
         rx_frame(fr);
      join
      e = exp_q.pop_front();
      checks++; if (fr.bits !== frame_bits(e)) begin errors++; $display("FAIL ignore_bits: got %b expected %b", fr.bits, frame_bits(e)); end
      checks++; if (fr.early_done) begin errors++; $display("FAIL ignore_early_done: tx_done inside frame, expected none"); end
      checks++; if (fr.done_lat != FRAME) begin errors++; $display("FAIL ignore_done_lat: got %0d expected %0d", fr.done_lat, FRAME); end
      dones = 0; lows = 0;
      repeat (60) begin
         @(negedge clk);
         if (tx_done === 1'b1) dones++;
         if (txd !== 1'b1) lows++;
      end
      checks++; if (dones != 0) begin errors++; $display("FAIL ignore_extra_done: got %0d pulses expected 0", dones); end
      checks++; if (lows != 0) begin errors++; $display("FAIL ignore_queued_frame: got %0d low cycles expected 0", lows); end
   endtask

   task automatic test_reset_mid();
      frame_t fr;
      logic [7:0] e;
      int dones, lows;
      @(negedge clk); tx_data = 8'h4F; tx_start = 1'b1;
      @(negedge clk); tx_start = 1'b0;
      repeat (17) @(negedge clk);  // inside data bit 3
      checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b expected 1", tx_busy); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (txd !== 1'b1) begin errors++; $display("FAIL rstmid_txd_async: got %b expected 1", txd); end
      checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy_async: got %b expected 0", tx_busy); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      dones = 0; lows = 0;
      repeat (50) begin
         @(negedge clk);
         if (tx_done === 1'b1) dones++;
         if (txd !== 1'b1) lows++;
      end
      checks++; if (dones != 0 || lows != 0) begin errors++; $display("FAIL rstmid_residue: got %0d done %0d low expected 0 0", dones, lows); end
      exp_q.push_back(8'h41);
      fork
         begin @(negedge clk); tx_data = 8'h41; tx_start = 1'b1; @(negedge clk); tx_start = 1'b0; end
         rx_frame(fr);
      join
      e = exp_q.pop_front();
      checks++; if (fr.bits !== frame_bits(e)) begin errors++; $display("FAIL rstmid_fresh_bits: got %b expected %b", fr.bits, frame_bits(e)); end
      checks++; if (fr.done_lat != FRAME) begin errors++; $display("FAIL rstmid_fresh_done_lat: got %0d expected %0d", fr.done_lat, FRAME); end
   endtask

`ifdef UART_TX_PARITY_EN
   task automatic test_parity();
      frame_t fr;
      logic [7:0] e;
      logic [7:0] vals [2];
      logic       pars [2];
      vals[0] = 8'h43; pars[0] = 1'b1;
      vals[1] = 8'h41; pars[1] = 1'b0;
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back(vals[i]);
         fork
            begin @(negedge clk); tx_data = vals[i]; tx_start = 1'b1; @(negedge clk); tx_start = 1'b0; end
            rx_frame(fr);
         join
         e = exp_q.pop_front();
         checks++; if (fr.bits !== frame_bits(e)) begin errors++; $display("FAIL parity_bits_%h: got %b expected %b", e, fr.bits, frame_bits(e)); end
         checks++; if (fr.bits[9] !== pars[i]) begin errors++; $display("FAIL parity_bit_%h: got %b expected %b", e, fr.bits[9], pars[i]); end
         checks++; if (fr.done_lat != 44) begin errors++; $display("FAIL parity_done_lat_%h: got %0d expected 44", e, fr.done_lat); end
         @(negedge clk);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_ignore_busy();
      test_reset_mid();
`ifdef UART_TX_PARITY_EN
      test_parity();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
